// File: rtl/wb_pkg.sv
// Shared writeback definitions: load-size encodings, FSM states, pending-load record.
// Latency: none; this file holds only constants, types and a pure helper function.
// Backpressure: not applicable.
package wb_pkg;

    // Load size encodings as presented by the memory stage; 2'b11 is reserved and behaves as a word.
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Architectural zero register; writes to it are always dropped.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the wait counter; TIMEOUT must fit in this many bits.
    localparam int CNT_W = 8;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    // Everything about an accepted load that is needed once its data returns.
    typedef struct packed {
        logic       reg_write;
        logic [4:0] dest;
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] addr_lo;
    } ld_pend_t;

    // A load is misaligned when its address is not a multiple of its access size.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            LD_BYTE: mis = 1'b0;
            LD_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half lane of a little-endian word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_extract
    import wb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   size,
    input  logic         is_unsigned,
    input  logic [1:0]   addr_lo,
    input  logic [W-1:0] raw,
    output logic [W-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_sign;
    logic        half_sign;

    // Lane selection: byte lane follows addr_lo, half lane follows addr_lo[1].
    always_comb begin
        byte_lane = raw[7:0];
        case (addr_lo)
            2'd0:    byte_lane = raw[7:0];
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            default: byte_lane = raw[31:24];
        endcase
        half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    assign byte_sign = ~is_unsigned & byte_lane[7];
    assign half_sign = ~is_unsigned & half_lane[15];

    // Extension to the datapath width; word (and reserved size) passes the raw word through.
    always_comb begin
        result = raw;
        case (size)
            LD_BYTE: result = {{(W-8){byte_sign}}, byte_lane};
            LD_HALF: result = {{(W-16){half_sign}}, half_lane};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: retires memory-stage ops into the register file, waiting for load data when needed.
// Latency: write_en one cycle after non-load acceptance or after ld_valid; loads time out after TIMEOUT wait cycles.
// Backpressure: in_ready low only while a load waits for data; ld_valid cannot be stalled.
// Optional macro REG_WRITEBACK_BYPASS_EN forwards the registered write into the read ports.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_reg_write,
    input  logic         in_is_load,
    input  logic [4:0]   in_dest,
    input  logic [W-1:0] in_result,
    input  logic [1:0]   in_ld_size,
    input  logic         in_ld_unsigned,
    input  logic [1:0]   in_addr_lo,
    input  logic         ld_valid,
    input  logic [W-1:0] ld_data,
    output logic         write_en,
    output logic [4:0]   write_reg_addr,
    output logic [W-1:0] write_reg_data,
    input  logic [4:0]   rf_rd_addr1,
    input  logic [4:0]   rf_rd_addr2,
    input  logic [W-1:0] rf_rd_data1,
    input  logic [W-1:0] rf_rd_data2,
    output logic [W-1:0] fwd_data1,
    output logic [W-1:0] fwd_data2,
    output logic         ld_spurious,
    output logic         ld_misalign,
    output logic         ld_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    wb_state_t        state_q;
    wb_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    ld_pend_t         pend_q;
    ld_pend_t         pend_d;

    logic             wr_en_d;
    logic [4:0]       wr_addr_d;
    logic [W-1:0]     wr_data_d;
    logic             spurious_set;
    logic             misalign_set;
    logic             timeout_set;
    logic [W-1:0]     ld_value;

    // Alignment and extension of the returning load, using the fields latched at acceptance.
    load_extract #(
        .W (W)
    ) u_load_extract (
        .size        (pend_q.size),
        .is_unsigned (pend_q.is_unsigned),
        .addr_lo     (pend_q.addr_lo),
        .raw         (ld_data),
        .result      (ld_value)
    );

    assign in_ready = (state_q == WB_IDLE);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state, pending-load capture, write request and error-flag set pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = write_reg_addr;
        wr_data_d    = write_reg_data;
        spurious_set = 1'b0;
        misalign_set = 1'b0;
        timeout_set  = 1'b0;

        case (state_q)
            WB_IDLE: begin
                // Nothing is outstanding, so any returning data is unexpected.
                if (ld_valid) begin
                    spurious_set = 1'b1;
                end
                if (in_valid) begin
                    if (!in_is_load) begin
                        if (in_reg_write && (in_dest != REG_ZERO)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_dest;
                            wr_data_d = in_result;
                        end
                    end else if (ld_misaligned(in_ld_size, in_addr_lo)) begin
                        // Retire the op without waiting; memory will not answer it.
                        misalign_set = 1'b1;
                    end else begin
                        pend_d.reg_write   = in_reg_write;
                        pend_d.dest        = in_dest;
                        pend_d.size        = in_ld_size;
                        pend_d.is_unsigned = in_ld_unsigned;
                        pend_d.addr_lo     = in_addr_lo;
                        cnt_d              = '0;
                        state_d            = WB_WAIT_LOAD;
                    end
                end
            end

            WB_WAIT_LOAD: begin
                // Data is checked before the timeout so a last-cycle return still retires.
                if (ld_valid) begin
                    if (pend_q.reg_write && (pend_q.dest != REG_ZERO)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pend_q.dest;
                        wr_data_d = ld_value;
                    end
                    cnt_d   = '0;
                    state_d = WB_IDLE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    timeout_set = 1'b1;
                    cnt_d       = '0;
                    state_d     = WB_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, wait counter and pending-load record; reset drops any outstanding load.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Registered register-file write port; address/data hold between writes.
    always_ff @(posedge CLK) begin
        if (reset) begin
            write_en       <= 1'b0;
            write_reg_addr <= REG_ZERO;
            write_reg_data <= '0;
        end else begin
            write_en <= wr_en_d;
            if (wr_en_d) begin
                write_reg_addr <= wr_addr_d;
                write_reg_data <= wr_data_d;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ld_spurious <= 1'b0;
            ld_misalign <= 1'b0;
            ld_timeout  <= 1'b0;
        end else begin
            ld_spurious <= ld_spurious | spurious_set;
            ld_misalign <= ld_misalign | misalign_set;
            ld_timeout  <= ld_timeout  | timeout_set;
        end
    end

`ifdef REG_WRITEBACK_BYPASS_EN
    // Forward the write in flight so decode sees it without a stall; register zero never forwards.
    always_comb begin
        fwd_data1 = rf_rd_data1;
        fwd_data2 = rf_rd_data2;
        if (write_en && (write_reg_addr == rf_rd_addr1) && (rf_rd_addr1 != REG_ZERO)) begin
            fwd_data1 = write_reg_data;
        end
        if (write_en && (write_reg_addr == rf_rd_addr2) && (rf_rd_addr2 != REG_ZERO)) begin
            fwd_data2 = write_reg_data;
        end
    end
`else
    // No forwarding: decode must stall an extra cycle on a read-after-write.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rf_rd_addr1, rf_rd_addr2};

    always_comb begin
        fwd_data1 = rf_rd_data1;
        fwd_data2 = rf_rd_data2;
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
// The model tracks one outstanding load and the cycle's expected register-file write.
module tb_reg_writeback;

    localparam int W   = 32;
    localparam int TMO = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_reg_write;
    logic         in_is_load;
    logic [4:0]   in_dest;
    logic [W-1:0] in_result;
    logic [1:0]   in_ld_size;
    logic         in_ld_unsigned;
    logic [1:0]   in_addr_lo;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         write_en;
    logic [4:0]   write_reg_addr;
    logic [W-1:0] write_reg_data;
    logic [4:0]   rf_rd_addr1;
    logic [4:0]   rf_rd_addr2;
    logic [W-1:0] rf_rd_data1;
    logic [W-1:0] rf_rd_data2;
    logic [W-1:0] fwd_data1;
    logic [W-1:0] fwd_data2;
    logic         ld_spurious;
    logic         ld_misalign;
    logic         ld_timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state
    bit          m_busy;
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_spur, m_mis, m_to;
    logic        p_rw;
    logic [4:0]  p_dest;
    int          p_nbytes;
    logic        p_uns;
    logic [1:0]  p_off;

    reg_writeback #(
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_is_load     (in_is_load),
        .in_dest        (in_dest),
        .in_result      (in_result),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_addr_lo     (in_addr_lo),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .write_en       (write_en),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .rf_rd_addr1    (rf_rd_addr1),
        .rf_rd_addr2    (rf_rd_addr2),
        .rf_rd_data1    (rf_rd_data1),
        .rf_rd_data2    (rf_rd_data2),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2),
        .ld_spurious    (ld_spurious),
        .ld_misalign    (ld_misalign),
        .ld_timeout     (ld_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian lane pick by shifting, then mask and extend from the lane's top bit.
    function automatic logic [31:0] ref_extract(input int nbytes, input logic uns,
                                                input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v    = (raw >> (8 * off)) & mask;
        if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    // Transaction-level model, advanced once per rising edge from the inputs of that cycle.
    task automatic model_step();
        if (reset) begin
            m_busy = 1'b0; m_wait = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_spur = 1'b0; m_mis = 1'b0; m_to = 1'b0;
            return;
        end
        m_we = 1'b0;
        if (!m_busy) begin
            if (ld_valid) m_spur = 1'b1;
            if (in_valid) begin
                if (!in_is_load) begin
                    if (in_reg_write && in_dest != 5'd0) begin
                        m_we = 1'b1; m_addr = in_dest; m_data = in_result;
                    end
                end else if ((int'(in_addr_lo) % size_bytes(in_ld_size)) != 0) begin
                    m_mis = 1'b1;
                end else begin
                    m_busy = 1'b1; m_wait = 0;
                    p_rw = in_reg_write; p_dest = in_dest;
                    p_nbytes = size_bytes(in_ld_size); p_uns = in_ld_unsigned; p_off = in_addr_lo;
                end
            end
        end else begin
            m_wait++;
            if (ld_valid) begin
                if (p_rw && p_dest != 5'd0) begin
                    m_we = 1'b1; m_addr = p_dest;
                    m_data = ref_extract(p_nbytes, p_uns, p_off, ld_data);
                end
                m_busy = 1'b0;
            end else if (m_wait == TMO) begin
                m_to = 1'b1; m_busy = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Per-cycle comparison against the model, on the falling edge.
    initial forever begin
        logic [31:0] e1, e2;
        @(negedge CLK);
        if (chk_en) begin
            chk("write_en", 32'(write_en), 32'(m_we));
            if (m_we) begin
                chk("write_reg_addr", 32'(write_reg_addr), 32'(m_addr));
                chk("write_reg_data", write_reg_data, m_data);
            end
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("ld_spurious", 32'(ld_spurious), 32'(m_spur));
            chk("ld_misalign", 32'(ld_misalign), 32'(m_mis));
            chk("ld_timeout", 32'(ld_timeout), 32'(m_to));
`ifdef REG_WRITEBACK_BYPASS_EN
            e1 = (m_we && m_addr == rf_rd_addr1 && rf_rd_addr1 != 5'd0) ? m_data : rf_rd_data1;
            e2 = (m_we && m_addr == rf_rd_addr2 && rf_rd_addr2 != 5'd0) ? m_data : rf_rd_data2;
`else
            e1 = rf_rd_data1;
            e2 = rf_rd_data2;
`endif
            chk("fwd_data1", fwd_data1, e1);
            chk("fwd_data2", fwd_data2, e2);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic put_op(input logic is_load, input logic [4:0] dest, input logic [31:0] res,
                          input logic [1:0] size, input logic uns, input logic [1:0] lo);
        in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = is_load; in_dest = dest;
        in_result = res; in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = lo;
    endtask

    task automatic byte_load_case(input logic uns, input logic [31:0] exp);
        put_op(1'b1, 5'd7, 32'h0, 2'b00, uns, 2'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("load_wait_ready", 32'(in_ready), 32'd0);
            if (i < 2) step();
        end
        ld_valid = 1'b1; ld_data = 32'h00AB_0000;
        step();
        chk("load_we", 32'(write_en), 32'd1);
        chk("load_addr", 32'(write_reg_addr), 32'd7);
        chk("load_data", write_reg_data, exp);
        chk("load_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_is_load = 1'b0;
        in_dest = '0; in_result = '0; in_ld_size = '0; in_ld_unsigned = 1'b0; in_addr_lo = '0;
        ld_valid = 1'b0; ld_data = '0;
        rf_rd_addr1 = '0; rf_rd_addr2 = '0; rf_rd_data1 = '0; rf_rd_data2 = '0;

        // Reset values
        step();
        step();
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_addr", 32'(write_reg_addr), 32'd0);
        chk("rst_data", write_reg_data, 32'd0);
        chk("rst_flags", {29'd0, ld_spurious, ld_misalign, ld_timeout}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Back-to-back non-loads
        put_op(1'b0, 5'd5, 32'h0000_1234, 2'b10, 1'b0, 2'd0);
        step();
        chk("b2b_we0", 32'(write_en), 32'd1);
        chk("b2b_addr0", 32'(write_reg_addr), 32'd5);
        chk("b2b_data0", write_reg_data, 32'h0000_1234);
        put_op(1'b0, 5'd6, 32'hFFFF_0000, 2'b10, 1'b0, 2'd0);
        step();
        chk("b2b_we1", 32'(write_en), 32'd1);
        chk("b2b_addr1", 32'(write_reg_addr), 32'd6);
        chk("b2b_data1", write_reg_data, 32'hFFFF_0000);
        step();
        chk("b2b_we_drop", 32'(write_en), 32'd0);

        // Byte load at lane 2, signed then unsigned
        byte_load_case(1'b0, 32'hFFFF_FFAB);
        // A new op is accepted in the same cycle the load's write is shown
        put_op(1'b0, 5'd3, 32'h55, 2'b10, 1'b0, 2'd0);
        step();
        chk("accept_on_we", {27'd0, write_reg_addr}, 32'd3);
        byte_load_case(1'b1, 32'h0000_00AB);
        step();

        // Register zero and misalignment
        put_op(1'b0, 5'd0, 32'hDEAD, 2'b10, 1'b0, 2'd0);
        step();
        chk("dest0_no_we", 32'(write_en), 32'd0);
        put_op(1'b1, 5'd4, 32'h0, 2'b01, 1'b0, 2'd1);
        step();
        chk("mis_no_we", 32'(write_en), 32'd0);
        chk("mis_flag", 32'(ld_misalign), 32'd1);
        chk("mis_ready", 32'(in_ready), 32'd1);

        // Data arriving on the last wait cycle beats the timeout (half load, upper lane)
        put_op(1'b1, 5'd10, 32'h0, 2'b01, 1'b0, 2'd2);
        step();
        step(); step(); step();
        ld_valid = 1'b1; ld_data = 32'h8001_7FFF;
        step();
        chk("edge_we", 32'(write_en), 32'd1);
        chk("edge_data", write_reg_data, 32'hFFFF_8001);
        chk("edge_no_timeout", 32'(ld_timeout), 32'd0);

        // Timeout with no data, then a spurious return
        put_op(1'b1, 5'd8, 32'h0, 2'b00, 1'b0, 2'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_ready", 32'(in_ready), {31'd0, i == 3});
        end
        step();
        chk("to_flag", 32'(ld_timeout), 32'd1);
        chk("to_ready", 32'(in_ready), 32'd1);
        chk("to_no_we", 32'(write_en), 32'd0);
        chk("to_no_spur", 32'(ld_spurious), 32'd0);
        ld_valid = 1'b1; ld_data = 32'h1111_1111;
        step();
        chk("spur_flag", 32'(ld_spurious), 32'd1);
        chk("spur_no_we", 32'(write_en), 32'd0);

        // Forwarding view of a write in flight
        put_op(1'b0, 5'd9, 32'h0000_CAFE, 2'b10, 1'b0, 2'd0);
        step();
        rf_rd_addr1 = 5'd9; rf_rd_data1 = 32'h1;
        rf_rd_addr2 = 5'd0; rf_rd_data2 = 32'h77;
        #1;
`ifdef REG_WRITEBACK_BYPASS_EN
        chk("fwd1_bypass", fwd_data1, 32'h0000_CAFE);
`else
        chk("fwd1_plain", fwd_data1, 32'h1);
`endif
        chk("fwd2_zero", fwd_data2, 32'h77);

        // Reset during a pending load
        put_op(1'b1, 5'd12, 32'h0, 2'b10, 1'b0, 2'd0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rml_ready", 32'(in_ready), 32'd1);
        chk("rml_we", 32'(write_en), 32'd0);
        chk("rml_addr", 32'(write_reg_addr), 32'd0);
        chk("rml_data", write_reg_data, 32'd0);
        chk("rml_flags", {29'd0, ld_spurious, ld_misalign, ld_timeout}, 32'd0);
        ld_valid = 1'b1; ld_data = 32'h2222_2222;
        step();
        chk("rml_late_no_we", 32'(write_en), 32'd0);
        chk("rml_late_spur", 32'(ld_spurious), 32'd1);

        // Randomized traffic; checking is done by the compare process
        for (int c = 0; c < 4000; c++) begin
            reset          = ($urandom_range(0, 299) == 0);
            in_valid       = ($urandom_range(0, 9) < 6);
            in_is_load     = ($urandom_range(0, 9) < 4);
            in_reg_write   = ($urandom_range(0, 9) < 8);
            in_dest        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_result      = $urandom;
            in_ld_size     = 2'($urandom_range(0, 3));
            in_ld_unsigned = 1'($urandom_range(0, 1));
            in_addr_lo     = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            ld_valid       = ($urandom_range(0, 9) < 3);
            ld_data        = $urandom;
            rf_rd_addr1    = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom_range(0, 31));
            rf_rd_addr2    = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom_range(0, 31));
            rf_rd_data1    = $urandom;
            rf_rd_data2    = $urandom;
            @(posedge CLK);
            #1;
        end
        reset = 1'b0; in_valid = 1'b0; ld_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage that owns the write side of the register file. It accepts retiring instructions from the memory stage over a valid/ready handshake and waits for load data when required. It aligns and sign-extends sub-word loads and drives the register file's `write_en`, `write_reg_addr` and `write_reg_data`. It optionally forwards the value being written into the register file's combinational read ports.

## Interface
Parameters:
- `W`, default 32: datapath width.
- `TIMEOUT`, default 255: maximum number of cycles spent in WAIT_LOAD; must fit in 8 bits.

Ports:
- `CLK`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: memory stage presents a retiring instruction.
- `in_ready`  out  1: stage can accept.
- `in_reg_write`  in  1: instruction writes a register.
- `in_is_load`  in  1: result comes from `ld_data`.
- `in_dest`  in  5: destination register.
- `in_result`  in  W: ALU result (non-load).
- `in_ld_size`  in  2: load size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `in_ld_unsigned`  in  1: zero-extend instead of sign-extend.
- `in_addr_lo`  in  2: low address bits of the load.
- `ld_valid`  in  1: load data returned (single-cycle pulse, no backpressure).
- `ld_data`  in  W: raw aligned word from memory.
- `write_en`, `write_reg_addr[4:0]`, `write_reg_data[W-1:0]`  out: register file write port; registered.
- `rf_rd_addr1`, `rf_rd_addr2`  in  5: register file read addresses.
- `rf_rd_data1`, `rf_rd_data2`  in  W: register file read data.
- `fwd_data1`, `fwd_data2`  out  W: read data for the decode stage.
- `ld_spurious`, `ld_misalign`, `ld_timeout`  out  1 each: sticky error flags.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE:
  - `in_ready`=1.
  - A non-load is accepted when `in_valid` is high. If `in_reg_write` is set and `in_dest`≠0, the next cycle shows `write_en`=1 with `in_dest` and `in_result`; otherwise no write.
  - Accepting a load latches dest, size, unsigned and addr_lo, then moves to WAIT_LOAD.
- Misaligned load (half with `in_addr_lo[0]`=1, or word with `in_addr_lo`≠0):
  - Accepted, but no WAIT_LOAD and no write.
  - Sets `ld_misalign`.
- WAIT_LOAD:
  - `in_ready`=0; the wait counter increments each cycle.
  - On `ld_valid`: extract the result, register the write (suppressed if dest=0), return to IDLE.
  - If the counter reaches `TIMEOUT`: set `ld_timeout`, no write, return to IDLE.
- Extraction (little-endian):
  - Byte uses lane `addr_lo`; half uses lane `addr_lo[1]`.
  - Sign bit is the MSB of the lane unless unsigned.
  - Word passes through.
- Spurious data: `ld_valid` while in IDLE is ignored and sets `ld_spurious`.
- Writes to register 0 are never issued.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `write_en`=0, `write_reg_addr`=0, `write_reg_data`=0.
  - All sticky flags 0.
  - `in_ready`=1 in the cycle after reset.
- Latency:
  - Non-load: `write_en` rises one cycle after acceptance.
  - Load: `write_en` rises one cycle after `ld_valid`.
  - Throughput is one non-load per cycle, back to back.
- `write_en` is high for exactly one cycle per write.
- `in_ready` returns to 1 in the same cycle the load's `write_en` is high, so a new op can be accepted in that cycle.
- `ld_valid` in the same cycle as the timeout edge: data wins and no timeout is flagged.
- Reset during WAIT_LOAD:
  - Pending load is dropped and no write is issued.
  - A later `ld_valid` sets `ld_spurious`.

## Configuration
- `REG_WRITEBACK_BYPASS_EN` defined:
  - `fwd_dataN` = `write_reg_data` when `write_en`=1, `write_reg_addr`=`rf_rd_addrN` and `rf_rd_addrN`≠0.
  - Otherwise `fwd_dataN` = `rf_rd_dataN`.
  - Combinational, zero latency.
- Undefined: `fwd_dataN` = `rf_rd_dataN` always. The pipeline must stall one extra cycle on a read-after-write.

## Structure
- Shared package `wb_pkg`:
  - Load-size encodings LD_BYTE, LD_HALF, LD_WORD.
  - State enum (WB_IDLE, WB_WAIT_LOAD).
  - Register-zero constant.
- Sub-module `load_extract`: combinational; inputs size, unsigned, addr_lo and raw word; output extended W-bit value.

## Test plan
- Non-load back to back: accept `in_dest`=5 with 0x1234 then `in_dest`=6 with 0xFFFF0000 on consecutive cycles → `write_en` on two consecutive cycles with (5,0x1234) then (6,0xFFFF0000).
- Load with sign extension: byte load, addr_lo=2, signed, dest=7, then `ld_valid` with 0x00AB0000 after 3 cycles → `in_ready`=0 for those cycles, then write (7,0xFFFFFFAB). Same load with unsigned set → write (7,0x000000AB).
- Destination 0 and misalignment: non-load to dest 0 → no write. Half load with addr_lo=1 → no write, `ld_misalign`=1, `in_ready` stays 1.
- Timeout: `TIMEOUT`=4, load accepted, no `ld_valid` → `ld_timeout` set after 4 WAIT cycles, no write, IDLE. A later `ld_valid` → `ld_spurious`=1.
- Bypass (macro defined): `write_en` with (9,0xCAFE) while `rf_rd_addr1`=9 and `rf_rd_data1`=0x1 → `fwd_data1`=0xCAFE. With `rf_rd_addr2`=0 → `fwd_data2`=`rf_rd_data2`.
- Reset mid-load: assert `reset` in WAIT_LOAD → next cycle IDLE and all outputs zero. A following `ld_valid` produces no write.
